serial_ripple_sub: RTL and testbench

SERIAL_RIPPLE_SUB -- requirements
Module: serial_ripple_sub

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/serial_ripple_sub_cell.sv | 14 +
 rtl/serial_ripple_sub.sv | 101 ++++++++++
 tb/tb_serial_ripple_sub.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial ripple subtractor.
// FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_ripple_sub_cell.sv
// Combinational one-bit full subtractor.
// Reused every RUN cycle by serial_ripple_sub.
module bit_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic br,
  output logic d_i,
  output logic br_next
);

  assign d_i     = a_i ^ b_i ^ br;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);

endmodule

// File: rtl/serial_ripple_sub.sv
// Bit-serial ripple subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_ripple_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res, res_n;
  logic [IW-1:0]    idx;
  logic             br, br_nx, d;
  logic             last;

  assign last = (idx == IW'(WIDTH - 1));

  bit_sub_cell u_cell (
    .a_i    (a_q[idx]),
    .b_i    (b_q[idx]),
    .br     (br),
    .d_i    (d),
    .br_next(br_nx)
  );

  always_comb begin
    state_n    = state;
    res_n      = res;
    res_n[idx] = d;
    unique case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res       <= '0;
      idx       <= '0;
      br        <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (state == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
        br  <= bin;
        idx <= '0;
        res <= '0;
      end
      if (state == RUN) begin
        res <= res_n;
        br  <= br_nx;
        idx <= idx + 1'b1;
        if (last) begin
          diff <= res_n;
          bout <= br_nx;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= br ^ br_nx;
  end
`endif

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Directed self-checking bench for serial_ripple_sub at WIDTH=2.
// Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_ripple_sub;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_ripple_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic offer(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic bi);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        diff !== 2'd0 || bout !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b diff=%0d bout=%b want 1 0 0 0",
               in_ready, out_valid, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] av [3] = '{2'd3, 2'd1, 2'd0};
    logic [W-1:0] bv [3] = '{2'd1, 2'd2, 2'd0};
    logic         iv [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] ed [3] = '{2'd2, 2'd3, 2'd3};
    logic         eb [3] = '{1'b0, 1'b1, 1'b1};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      offer(av[i], bv[i], iv[i]);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic%0d_run: rdy=%b vld=%b want 0 0",
                 i, in_ready, out_valid);
      end
      wait_valid(cyc);
      checks++;
      if (cyc !== W) begin
        failures++;
        $display("FAIL basic%0d_latency: got %0d want %0d", i, cyc, W);
      end
      checks++;
      if (diff !== ed[i] || bout !== eb[i]) begin
        failures++;
        $display("FAIL basic%0d_result: diff=%0d bout=%b want %0d %b",
                 i, diff, bout, ed[i], eb[i]);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL basic%0d_drain: vld=%b rdy=%b want 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_ignore_offer();
    int cyc;
    offer(2'd3, 2'd1, 1'b0);
    a        = 2'd0;
    b        = 2'd3;
    bin      = 1'b1;
    in_valid = 1'b1;
    wait_valid(cyc);
    checks++;
    if (cyc !== W || diff !== 2'd2 || bout !== 1'b0) begin
      failures++;
      $display("FAIL ignore_offer: cyc=%0d diff=%0d bout=%b want %0d 2 0",
               cyc, diff, bout, W);
    end
    in_valid = 1'b0;
    consume();
  endtask

  task automatic test_hold();
    int cyc;
    offer(2'd1, 2'd2, 1'b0);
    wait_valid(cyc);
    a        = 2'd2;
    b        = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || diff !== 2'd3 ||
          bout !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d: vld=%b diff=%0d bout=%b rdy=%b want 1 3 1 0",
                 i, out_valid, diff, bout, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    offer(2'd3, 2'd1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b vld=%b diff=%0d want 1 0 0",
               in_ready, out_valid, diff);
    end
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    checks++;
    if (cyc !== 0) begin
      failures++;
      $display("FAIL reset_mid_pulse: got %0d valid cycles want 0", cyc);
    end
    offer(2'd2, 2'd1, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc !== W || diff !== 2'd1 || bout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fresh: cyc=%0d diff=%0d bout=%b want %0d 1 0",
               cyc, diff, bout, W);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_out_ready: vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    offer(2'd3, 2'd3, 1'b1);
    wait_valid(cyc);
    checks++;
    if (cyc !== W || diff !== 2'd3 || bout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: cyc=%0d diff=%0d bout=%b want %0d 3 1",
               cyc, diff, bout, W);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    offer(2'd2, 2'd0, 1'b1);
    wait_valid(cyc);
    checks++;
    if (cyc !== W || diff !== 2'd1 || bout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: cyc=%0d diff=%0d bout=%b want %0d 1 0",
               cyc, diff, bout, W);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ovf: got %b want 1", ovf);
    end
`endif
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int cyc;
    offer(2'd1, 2'd2, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc !== W || diff !== 2'd3 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: cyc=%0d diff=%0d ovf=%b want %0d 3 1",
               cyc, diff, ovf, W);
    end
    consume();
    offer(2'd1, 2'd1, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc !== W || diff !== 2'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: cyc=%0d diff=%0d ovf=%b want %0d 0 0",
               cyc, diff, ovf, W);
    end
    consume();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ignore_offer();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
